// File: rtl/cv32e40px_illegal_insn_fifo.sv
// Capture buffer for illegal-instruction events seen at decode.
// Each new event (de-duplicated against a stalled ID stage) is tagged with a
// wrapping sequence number and queued. A valid/ready port drains the queue.
// Detection never back-pressures the core: a full queue drops the event and
// records the drop instead.
module cv32e40px_illegal_insn_fifo #(
  parameter int DEPTH     = 4,
  parameter int SEQ_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       is_decoding_i,
  input  logic                       illegal_insn_dec_i,
  input  logic [31:0]                hart_id_i,
  input  logic [31:0]                pc_id_i,
  input  logic                       clear_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [31:0]                evt_pc_o,
  output logic [3:0]                 evt_hart_o,
  output logic [SEQ_WIDTH-1:0]       evt_seq_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [CNT_WIDTH-1:0]       total_cnt_o,
  output logic [CNT_WIDTH-1:0]       drop_cnt_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [31:0]          pc;
    logic [3:0]           hart;
    logic [SEQ_WIDTH-1:0] seq;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic                 ovf_q, ovf_d;
  logic                 hit_q, hit_d;
  logic [31:0]          pc_q, pc_d;

  logic hit, det, empty, full, pop, push, drop;

  // Only the low hart ID bits are recorded.
  logic unused_hart_bits;
  assign unused_hart_bits = ^hart_id_i[31:4];

  // Pointers carry one extra wrap bit: equal => empty, only the wrap bit
  // differing => full.
  always_comb begin
    hit   = is_decoding_i & illegal_insn_dec_i;
    // A stalled illegal instruction keeps hit high with the same PC; only
    // its first cycle counts as an event.
    det   = hit & ~(hit_q & (pc_q == pc_id_i)) & ~clear_i;
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop   = ~empty & evt_ready_i & ~clear_i;
    push  = det & (~full | pop);
    drop  = det & full & ~pop;
  end

  // Next-state for queue storage, pointers, counters and de-dup history.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    seq_d   = seq_q;
    total_d = total_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    hit_d   = hit;
    pc_d    = pc_id_i;

    if (clear_i) begin
      // Storage contents are left alone; with both pointers at zero they
      // are unreachable until overwritten.
      wptr_d  = '0;
      rptr_d  = '0;
      seq_d   = '0;
      total_d = '0;
      drop_d  = '0;
      ovf_d   = 1'b0;
      hit_d   = 1'b0;
      pc_d    = '0;
    end else begin
      if (pop) rptr_d = rptr_q + PW'(1);
      if (push) begin
        mem_d[wptr_q[AW-1:0]] = '{pc: pc_id_i, hart: hart_id_i[3:0], seq: seq_q};
        wptr_d = wptr_q + PW'(1);
      end
      if (det) begin
        // Dropped events still consume a sequence number so gaps are visible.
        seq_d = seq_q + SEQ_WIDTH'(1);
        if (total_q != '1) total_d = total_q + CNT_WIDTH'(1);
      end
      if (drop) begin
        if (drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
        ovf_d = 1'b1;
      end
    end
  end

  // State registers; reset also zeroes storage so head outputs read 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      seq_q   <= '0;
      total_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      hit_q   <= 1'b0;
      pc_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      seq_q   <= seq_d;
      total_q <= total_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      hit_q   <= hit_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs come straight from registers: no input-to-output path.
  always_comb begin
    evt_valid_o = ~empty;
    evt_pc_o    = mem_q[rptr_q[AW-1:0]].pc;
    evt_hart_o  = mem_q[rptr_q[AW-1:0]].hart;
    evt_seq_o   = mem_q[rptr_q[AW-1:0]].seq;
    level_o     = wptr_q - rptr_q;
    total_cnt_o = total_q;
    drop_cnt_o  = drop_q;
    overflow_o  = ovf_q;
  end

endmodule
